vproc_mem_arbiter: RTL and testbench

Two-port to one-port memory arbiter that shares the single core memory interface between the instruction-fetch requester (port 0) and the data/vector-load-store requester (port 1). It grants at most one request per cycle, tracks outstanding requests in an in-order source-ID FIFO, and routes each `mem_rvalid_i` response back to the port that issued it. It sits between the core/vector-unit request ports and the `mem_*` bus driven towards the memory model or cache.

---
 rtl/vproc_mem_arbiter.sv | 134 +++++++++++++
 tb/tb_vproc_mem_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vproc_mem_arbiter.sv
// rtl/vproc_mem_arbiter.sv - two-port to one-port memory arbiter with in-order response routing
// Macro VPROC_MEM_ARB_RR_EN selects round-robin arbitration; otherwise port 1 has fixed priority.
module vproc_mem_arbiter #(
  parameter int unsigned MEM_W     = 32,
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [1:0]                     req_i,
  input  logic [1:0][31:0]               addr_i,
  input  logic [1:0]                     we_i,
  input  logic [1:0][MEM_W/8-1:0]        be_i,
  input  logic [1:0][MEM_W-1:0]          wdata_i,
  output logic [1:0]                     gnt_o,
  output logic [1:0]                     rvalid_o,
  output logic [MEM_W-1:0]               rdata_o,
  output logic                           err_o,
  output logic                           mem_req_o,
  output logic [31:0]                    mem_addr_o,
  output logic                           mem_we_o,
  output logic [MEM_W/8-1:0]             mem_be_o,
  output logic [MEM_W-1:0]               mem_wdata_o,
  input  logic                           mem_rvalid_i,
  input  logic                           mem_err_i,
  input  logic [MEM_W-1:0]               mem_rdata_i,
  output logic [$clog2(MAX_OUTST):0]     outst_cnt_o,
  output logic                           spurious_o
);

  localparam int unsigned PTR_W = $clog2(MAX_OUTST);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTST);

  logic [MAX_OUTST-1:0] id_q;
  logic [PTR_W-1:0]     wptr_q;
  logic [PTR_W-1:0]     rptr_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 spurious_q;

  logic fifo_empty;
  logic can_issue;
  logic win;
  logic push;
  logic pop;
  logic gnt_id;
  logic head_id;

  assign fifo_empty = (cnt_q == '0);
  // A response in the same cycle frees a slot, so a full FIFO never causes a bubble.
  assign can_issue  = (cnt_q < FULL_CNT) | mem_rvalid_i;

`ifdef VPROC_MEM_ARB_RR_EN
  logic last_q;

  always_comb begin
    win = req_i[1];
    if (req_i == 2'b11) begin
      win = ~last_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last_q <= 1'b0;
    end else if (push) begin
      last_q <= gnt_id;
    end
  end
`else
  assign win = req_i[1];
`endif

  always_comb begin
    gnt_o = 2'b00;
    if (rst_ni && can_issue && (req_i != 2'b00)) begin
      gnt_o = win ? 2'b10 : 2'b01;
    end
  end

  assign push   = gnt_o[1] | gnt_o[0];
  assign gnt_id = gnt_o[1];

  // With an empty FIFO the only possible owner of a response is the request being pushed now.
  assign head_id = fifo_empty ? gnt_id : id_q[rptr_q];
  assign pop     = rst_ni & mem_rvalid_i & (~fifo_empty | push);

  always_comb begin
    rvalid_o = 2'b00;
    if (pop) begin
      rvalid_o = head_id ? 2'b10 : 2'b01;
    end
  end

  assign rdata_o = rst_ni ? mem_rdata_i : '0;
  assign err_o   = rst_ni & mem_err_i;

  assign mem_req_o   = push;
  assign mem_addr_o  = push ? addr_i[gnt_id]  : '0;
  assign mem_we_o    = push & we_i[gnt_id];
  assign mem_be_o    = push ? be_i[gnt_id]    : '0;
  assign mem_wdata_o = push ? wdata_i[gnt_id] : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      spurious_q <= 1'b0;
    end else begin
      if (push) begin
        id_q[wptr_q] <= gnt_id;
        wptr_q       <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      if (push && !pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (pop && !push) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (mem_rvalid_i && !pop) begin
        spurious_q <= 1'b1;
      end
    end
  end

  assign outst_cnt_o = cnt_q;
  assign spurious_o  = spurious_q;

  assert property (@(posedge clk_i) $onehot0(gnt_o));
  assert property (@(posedge clk_i) (gnt_o & ~req_i) == 2'b00);

endmodule

// File: tb/tb_vproc_mem_arbiter.sv
// tb/tb_vproc_mem_arbiter.sv - self-checking bench for vproc_mem_arbiter
// Build with or without VPROC_MEM_ARB_RR_EN; expected grant tables follow the macro.
module tb_vproc_mem_arbiter;

  localparam int MEM_W     = 32;
  localparam int MAX_OUTST = 4;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic [1:0]      req_i;
  logic [1:0][31:0] addr_i;
  logic [1:0]      we_i;
  logic [1:0][3:0] be_i;
  logic [1:0][31:0] wdata_i;
  logic [1:0]      gnt_o;
  logic [1:0]      rvalid_o;
  logic [31:0]     rdata_o;
  logic            err_o;
  logic            mem_req_o;
  logic [31:0]     mem_addr_o;
  logic            mem_we_o;
  logic [3:0]      mem_be_o;
  logic [31:0]     mem_wdata_o;
  logic            mem_rvalid_i;
  logic            mem_err_i;
  logic [31:0]     mem_rdata_i;
  logic [2:0]      outst_cnt_o;
  logic            spurious_o;

  vproc_mem_arbiter #(.MEM_W(MEM_W), .MAX_OUTST(MAX_OUTST)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .addr_i(addr_i), .we_i(we_i),
    .be_i(be_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .err_o(err_o), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_err_i(mem_err_i), .mem_rdata_i(mem_rdata_i),
    .outst_cnt_o(outst_cnt_o), .spurious_o(spurious_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic port; logic we; logic [31:0] data; logic err; } sb_t;
  typedef struct { int due; logic [31:0] data; logic err; } rsp_t;
  typedef struct packed { logic [1:0] req; logic [1:0] gnt; } vec_t;

  sb_t         sb[$];
  rsp_t        pend[$];
  logic [31:0] env_mem [bit [31:0]];
  logic [31:0] ref_mem [bit [31:0]];
  logic [1:0]  rv_log[$];
  logic [31:0] rd_log[$];
  logic        er_log[$];
  vec_t        tbl[8];

  int   lat;
  int   cyc;
  bit   inject;
  bit   model_last;
  bit   model_spur;
  int   n_pass;
  int   n_total;
  logic [1:0] obs_gnt;
  logic [1:0] obs_rv;
  logic [1:0] model_g;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [1:0] model_arb(input logic [1:0] req);
    if (req == 2'b00) return 2'b00;
    if (req == 2'b01) return 2'b01;
    if (req == 2'b10) return 2'b10;
`ifdef VPROC_MEM_ARB_RR_EN
    return model_last ? 2'b01 : 2'b10;
`else
    return 2'b10;
`endif
  endfunction

  // One clock cycle: drive the memory response, compare at negedge, update model and environment.
  task automatic step();
    logic [1:0] eg;
    logic [1:0] er;
    bit         can;
    bit         pop_e;
    sb_t        ne;
    sb_t        head;
    rsp_t       r;
    mem_rvalid_i = 1'b0;
    mem_err_i    = 1'b0;
    mem_rdata_i  = '0;
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = pend[0].data;
      mem_err_i    = pend[0].err;
      pend.delete(0);
    end else if (inject) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'h5a5a_5a5a;
    end
    @(negedge clk_i);
    can = (sb.size() < MAX_OUTST) || mem_rvalid_i;
    eg  = (rst_ni && can) ? model_arb(req_i) : 2'b00;
    ne.port = 1'b0; ne.we = 1'b0; ne.data = '0; ne.err = 1'b0;
    if (eg != 2'b00) begin
      ne.port = eg[1];
      ne.we   = we_i[ne.port];
      ne.err  = addr_i[ne.port][31];
      ne.data = ref_mem.exists(addr_i[ne.port]) ? ref_mem[addr_i[ne.port]] : 32'h0;
      if (ne.we) ref_mem[addr_i[ne.port]] = wdata_i[ne.port];
    end
    er = 2'b00;
    pop_e = 1'b0;
    head = ne;
    if (rst_ni && mem_rvalid_i) begin
      if (sb.size() != 0) begin head = sb[0]; pop_e = 1'b1; end
      else if (eg != 2'b00) pop_e = 1'b1;
      if (pop_e) er = head.port ? 2'b10 : 2'b01;
    end
    obs_gnt = gnt_o;
    obs_rv  = rvalid_o;
    model_g = eg;
    check("gnt", gnt_o, eg);
    check("mem_req", mem_req_o, eg != 2'b00);
    check("mem_addr", mem_addr_o, eg != 2'b00 ? addr_i[eg[1]] : 32'h0);
    check("mem_we", mem_we_o, eg != 2'b00 ? we_i[eg[1]] : 1'b0);
    check("mem_be", mem_be_o, eg != 2'b00 ? be_i[eg[1]] : 4'h0);
    check("rvalid", rvalid_o, er);
    if (pop_e) begin
      check("err", err_o, head.err);
      if (!head.we) check("rdata", rdata_o, head.data);
    end
    check("outst_cnt", outst_cnt_o, sb.size());
    check("spurious", spurious_o, model_spur);
    if (rvalid_o != 2'b00) begin
      rv_log.push_back(rvalid_o);
      rd_log.push_back(rdata_o);
      er_log.push_back(err_o);
    end
    if (mem_req_o) begin
      r.due  = cyc + lat;
      r.err  = mem_addr_o[31];
      r.data = env_mem.exists(mem_addr_o) ? env_mem[mem_addr_o] : 32'h0;
      if (mem_we_o) env_mem[mem_addr_o] = mem_wdata_o;
      pend.push_back(r);
    end
    if (!rst_ni) begin
      sb.delete();
      model_last = 1'b0;
      model_spur = 1'b0;
    end else begin
      if (eg != 2'b00) begin
        sb.push_back(ne);
        model_last = eg[1];
      end
      if (pop_e) sb.delete(0);
      else if (mem_rvalid_i) model_spur = 1'b1;
    end
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    req_i  = 2'b11;
    inject = 1'b0;
    step();
    step();
    rst_ni = 1'b1;
    req_i  = 2'b00;
  endtask

  task automatic issue(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
    bit done;
    done = 1'b0;
    req_i[p]   = 1'b1;
    we_i[p]    = we;
    addr_i[p]  = a;
    wdata_i[p] = d;
    for (int i = 0; i < 20 && !done; i++) begin
      step();
      done = model_g[p];
    end
    if (!done) check("issue_timeout", 32'd0, 32'd1);
    req_i[p] = 1'b0;
  endtask

  task automatic drain(input int n);
    req_i = 2'b00;
    repeat (n) step();
  endtask

  task automatic clear_logs();
    rv_log.delete();
    rd_log.delete();
    er_log.delete();
  endtask

  initial begin
    int ngr;
    n_pass = 0; n_total = 0; cyc = 0; lat = 1; inject = 1'b0;
    model_last = 1'b0; model_spur = 1'b0;
    rst_ni = 1'b0; req_i = 2'b00; we_i = 2'b00; be_i = {4'hF, 4'hF};
    addr_i = '0; wdata_i = '0;
    mem_rvalid_i = 1'b0; mem_err_i = 1'b0; mem_rdata_i = '0;
    env_mem[32'h100] = 32'hDEAD_BEEF;
    ref_mem[32'h100] = 32'hDEAD_BEEF;
    @(posedge clk_i);
    #1;

    do_reset();
    check("reset_cnt", outst_cnt_o, 32'd0);
    check("reset_spurious", spurious_o, 32'd0);

    // Single read, latency 1.
    clear_logs();
    issue(0, 1'b0, 32'h100, 32'h0);
    check("single_gnt", obs_gnt, 32'h1);
    check("single_cnt1", outst_cnt_o, 32'd1);
    step();
    check("single_cnt0", outst_cnt_o, 32'd0);
    check("single_rv_n", rv_log.size(), 32'd1);
    if (rv_log.size() >= 1) begin
      check("single_rv", rv_log[0], 32'h1);
      check("single_rdata", rd_log[0], 32'hDEAD_BEEF);
    end

    // Arbitration table, latency 1.
    tbl[0] = '{req: 2'b11, gnt: 2'b10};
`ifdef VPROC_MEM_ARB_RR_EN
    tbl[1] = '{req: 2'b11, gnt: 2'b01};
    tbl[2] = '{req: 2'b11, gnt: 2'b10};
    tbl[3] = '{req: 2'b11, gnt: 2'b01};
    tbl[7] = '{req: 2'b11, gnt: 2'b01};
`else
    tbl[1] = '{req: 2'b11, gnt: 2'b10};
    tbl[2] = '{req: 2'b11, gnt: 2'b10};
    tbl[3] = '{req: 2'b11, gnt: 2'b10};
    tbl[7] = '{req: 2'b11, gnt: 2'b10};
`endif
    tbl[4] = '{req: 2'b01, gnt: 2'b01};
    tbl[5] = '{req: 2'b10, gnt: 2'b10};
    tbl[6] = '{req: 2'b00, gnt: 2'b00};
    do_reset();
    lat = 1;
    addr_i[0] = 32'h100; addr_i[1] = 32'h104; we_i = 2'b00;
    for (int i = 0; i < 8; i++) begin
      req_i = tbl[i].req;
      step();
      check($sformatf("tbl_gnt[%0d]", i), obs_gnt, tbl[i].gnt);
    end
    drain(3);

    // Full FIFO, latency 8.
    do_reset();
    lat = 8;
    addr_i[0] = 32'h100; we_i = 2'b00;
    req_i = 2'b01;
    ngr = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (obs_gnt == 2'b01) ngr++;
    end
    check("full_grants", ngr, 32'd4);
    check("full_cnt", outst_cnt_o, 32'd4);
    step();
    check("full_refill_gnt", obs_gnt, 32'h1);
    check("full_refill_rv", obs_rv, 32'h1);
    check("full_cnt_after", outst_cnt_o, 32'd4);
    drain(16);
    check("full_drained", outst_cnt_o, 32'd0);

    // Interleaved routing, latency 3.
    do_reset();
    lat = 3;
    clear_logs();
    issue(1, 1'b1, 32'h40, 32'hCAFE_F00D);
    issue(0, 1'b0, 32'h100, 32'h0);
    issue(1, 1'b0, 32'h40, 32'h0);
    drain(6);
    check("ilv_rv_n", rv_log.size(), 32'd3);
    if (rv_log.size() == 3) begin
      check("ilv_rv0", rv_log[0], 32'h2);
      check("ilv_rv1", rv_log[1], 32'h1);
      check("ilv_rv2", rv_log[2], 32'h2);
      check("ilv_rdata", rd_log[2], 32'hCAFE_F00D);
      check("ilv_err", {er_log[0], er_log[1], er_log[2]}, 32'h0);
    end

    // Out-of-range read and spurious response.
    lat = 1;
    clear_logs();
    issue(0, 1'b0, 32'h8000_0000, 32'h0);
    step();
    check("oor_rv_n", rv_log.size(), 32'd1);
    if (rv_log.size() == 1) begin
      check("oor_rv", rv_log[0], 32'h1);
      check("oor_err", er_log[0], 32'h1);
    end
    inject = 1'b1;
    step();
    inject = 1'b0;
    check("spur_rv", obs_rv, 32'h0);
    check("spur_flag", spurious_o, 32'h1);
    check("spur_cnt", outst_cnt_o, 32'd0);
    step();
    check("spur_sticky", spurious_o, 32'h1);

    // Mid-flight reset, latency 5.
    do_reset();
    check("rst_clears_spur", spurious_o, 32'h0);
    lat = 5;
    addr_i[0] = 32'h100; we_i = 2'b00;
    req_i = 2'b01;
    repeat (3) step();
    check("mid_cnt", outst_cnt_o, 32'd3);
    rst_ni = 1'b0;
    req_i = 2'b11;
    ngr = 0;
    repeat (2) begin
      step();
      if (obs_gnt != 2'b00) ngr++;
    end
    rst_ni = 1'b1;
    req_i = 2'b00;
    check("mid_rst_grants", ngr, 32'd0);
    check("mid_rst_cnt", outst_cnt_o, 32'd0);
    clear_logs();
    drain(6);
    check("mid_stale_rv", rv_log.size(), 32'd0);
    check("mid_stale_spur", spurious_o, 32'h1);
    check("mid_final_cnt", outst_cnt_o, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
